mdu_seq: RTL and testbench
==========================

# mdu_seq

Multi-cycle sequencer for the RV32M multiply/divide operations, sitting between the execute stage and writeback. It accepts one M-op at a time over a valid/ready handshake and computes multiplies in a registered single step. Divides and remainders use a 32-iteration restoring divider, with the RISC-V special cases (divide-by-zero, signed overflow) resolved on a short path. The result is held until the consumer takes it.

## Interface
- Parameters: none. The iteration count `DIV_ITER = 32` is a package constant.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  sequencer can accept a request; high only in IDLE.
- `i_op`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_x`  in  32  rs1 operand.
- `i_y`  in  32  rs2 operand.
- `i_flush`  in  1  abort any in-flight op (pipeline kill).
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts the result.
- `o_res`  out  32  result; stable while `o_valid && !i_ready`.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Accept:** `i_valid && o_ready && !i_flush`. On accept, latch op, operands and operand signs.
- **Accept transitions:**
  - op[2]=0 → MUL.
  - op[2]=1 with `i_y==0` → DONE, with the special result precomputed.
  - op[2]=1 with signed overflow (op 100/110, x=0x80000000, y=0xFFFFFFFF) → DONE, with the special result precomputed.
  - Otherwise → DIV, with iteration counter = 31.
- **MUL operand extension to 64 bits:**
  - MUL/MULH: both operands signed.
  - MULHSU: x signed, y unsigned.
  - MULHU: both unsigned.
- **MUL result:** MUL takes prod[31:0]; the other three take prod[63:32]. Result registered, then → DONE.
- **DIV setup:**
  - Signed ops (100/110) take absolute values of x and y and record the quotient sign (`x[31]^y[31]`) and remainder sign (`x[31]`).
  - Unsigned ops use the operands as-is.
- **DIV iteration (one restoring step per cycle):**
  - Remainder register is 33 bits; quotient/dividend shift register is 32 bits.
  - Trial-subtract the divisor from {rem, next dividend bit}. If the result is non-negative, keep it and shift in q=1; otherwise shift in q=0.
  - The counter decrements each step. The step at counter 0 writes the sign-corrected quotient or remainder (per op) to the result register, then → DONE.
- **Special results:**
  - Divide-by-zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give x.
  - Overflow: DIV gives 0x80000000; REM gives 0.
- **DONE:** `o_valid=1`. On `i_ready` → IDLE.
- **Flush:**
  - `i_flush` in any state → IDLE at the next edge; `o_valid` drops and the result is discarded.
  - Flush in IDLE with `i_valid` → no accept.
- **Reset:** → IDLE. Outputs after reset: `o_ready=1`, `o_valid=0`, `o_res=0`. Internal counters and registers are cleared. Reset overrides flush and accept.

## Timing
- **Accept** is in cycle T (the edge ending T).
- **Latency:**
  - MUL ops: `o_valid` in T+2.
  - Div/rem special cases: `o_valid` in T+1 (DONE entered directly).
  - Normal DIV: 32 DIV cycles (T+1..T+32); `o_valid` in T+33.
- **Handshake:**
  - No new accept until the result handshake completes.
  - `o_ready` rises in the cycle after `o_valid && i_ready`, so one request completes per latency+1 cycles.
- **Stability:** `o_res` and `o_valid` must not change while `o_valid && !i_ready`, unless `i_flush` or `i_rst` is asserted.
- **Operand isolation:** `i_x`, `i_y` and `i_op` are ignored outside the accept cycle.

## Structure
- **Package `mdu_pkg`:**
  - `mdu_op_e` enum with the eight encodings.
  - `mdu_state_e` enum (IDLE, MUL, DIV, DONE).
  - `DIV_ITER` = 32.
  - Functions `is_div(op)` and `is_signed_div(op)`.
- **Sub-module `mdu_div_step`:** combinational single restoring step.
  - Inputs: 33-bit remainder, dividend bit, 32-bit divisor.
  - Outputs: next remainder, quotient bit.
- **Top level:** the FSM, operand/sign latches, 64-bit multiply and the result register live in `mdu_seq`.

## Test plan
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB with `o_valid` in T+2; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD and REM → 0xFFFFFFFF, `o_valid` in T+33; DIVU 100 / 7 → 14 and REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5 in T+1; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0 in T+1.
- Backpressure: hold `i_ready=0` for 5 cycles in DONE → `o_res` and `o_valid` constant and `o_ready` low; `i_ready=1` → `o_ready=1` next cycle.
- Assert `i_flush` at DIV iteration 10 → next cycle IDLE, `o_ready=1`, no `o_valid`; a following MUL 3 × 4 → 12 correctly.
- Assert `i_rst` mid-DIV and in DONE → next cycle `o_valid=0`, `o_res=0`, `o_ready=1`; `i_valid` with `i_flush` in IDLE → not accepted.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types, constants and helpers for the RV32M sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int DIV_ITER = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_div(mdu_op_e op);
        return op >= OP_DIV;
    endfunction

    function automatic logic is_signed_div(mdu_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq_if
// Description : Request/result handshake bundle for the M-op sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_seq_if;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_x;
    logic [31:0] i_y;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_res;

    modport slave (
        input  i_valid, i_op, i_x, i_y, i_flush, i_ready,
        output o_ready, o_valid, o_res
    );

    modport master (
        output i_valid, i_op, i_x, i_y, i_flush, i_ready,
        input  o_ready, o_valid, o_res
    );
endinterface
`default_nettype wire

// File: rtl/mdu_seq_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_div_step
// Description : One combinational restoring-division step.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_step (
    input  logic [32:0] i_rem,
    input  logic        i_bit,
    input  logic [31:0] i_divisor,
    output logic [32:0] o_rem,
    output logic        o_q
);
    logic [33:0] w_shift;
    logic [33:0] w_diff;

    // One extra bit on top so the borrow of the trial subtract is visible.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {2'b00, i_divisor};
    assign o_q     = ~w_diff[33];
    assign o_rem   = o_q ? w_diff[32:0] : w_shift[32:0];
endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq
// Description : Multi-cycle RV32M multiply/divide sequencer with result hold.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq
    import mdu_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    mdu_seq_if.slave   bus
);
    mdu_state_e  r_state;
    mdu_state_e  w_state_nxt;
    mdu_op_e     r_op;
    mdu_op_e     w_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_res;
    logic [32:0] r_rem;
    logic [4:0]  r_cnt;
    logic        r_qneg;
    logic        r_rneg;

    logic        w_accept;
    logic        w_ready;
    logic        w_valid;
    logic        w_sdiv;
    logic        w_y_zero;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_res;
    logic [31:0] w_x_abs;
    logic [31:0] w_y_abs;

    logic        w_x_sx;
    logic        w_y_sx;
    logic [63:0] w_x_ext;
    logic [63:0] w_y_ext;
    logic [63:0] w_prod;
    logic [31:0] w_mul_res;

    logic [32:0] w_rem_nxt;
    logic        w_q;
    logic [31:0] w_quo;
    logic        w_is_rem;
    logic [31:0] w_div_res;

    // ---------------- request decode ----------------
    assign w_op      = mdu_op_e'(bus.i_op);
    assign w_sdiv    = is_signed_div(w_op);
    assign w_y_zero  = (bus.i_y == 32'd0);
    assign w_ovf     = w_sdiv && (bus.i_x == 32'h8000_0000) && (bus.i_y == 32'hFFFF_FFFF);
    assign w_special = is_div(w_op) && (w_y_zero || w_ovf);
    assign w_x_abs   = (w_sdiv && bus.i_x[31]) ? (32'd0 - bus.i_x) : bus.i_x;
    assign w_y_abs   = (w_sdiv && bus.i_y[31]) ? (32'd0 - bus.i_y) : bus.i_y;

    always_comb begin
        w_special_res = 32'd0;
        if (w_y_zero) begin
            w_special_res = ((w_op == OP_REM) || (w_op == OP_REMU)) ? bus.i_x : 32'hFFFF_FFFF;
        end else if (w_op == OP_DIV) begin
            w_special_res = 32'h8000_0000;
        end
    end

    // ---------------- multiply ----------------
    assign w_x_sx    = (r_op == OP_MUL) || (r_op == OP_MULH) || (r_op == OP_MULHSU);
    assign w_y_sx    = (r_op == OP_MUL) || (r_op == OP_MULH);
    assign w_x_ext   = {{32{w_x_sx & r_a[31]}}, r_a};
    assign w_y_ext   = {{32{w_y_sx & r_b[31]}}, r_b};
    assign w_prod    = w_x_ext * w_y_ext;
    assign w_mul_res = (r_op == OP_MUL) ? w_prod[31:0] : w_prod[63:32];

    // ---------------- divide ----------------
    mdu_div_step u_div_step (
        .i_rem     (r_rem),
        .i_bit     (r_a[31]),
        .i_divisor (r_b),
        .o_rem     (w_rem_nxt),
        .o_q       (w_q)
    );

    assign w_quo     = {r_a[30:0], w_q};
    assign w_is_rem  = (r_op == OP_REM) || (r_op == OP_REMU);
    assign w_div_res = w_is_rem ? (r_rneg ? (32'd0 - w_rem_nxt[31:0]) : w_rem_nxt[31:0])
                                : (r_qneg ? (32'd0 - w_quo) : w_quo);

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_valid     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.i_valid && !bus.i_flush) begin
                    w_accept = 1'b1;
                    if (!is_div(w_op)) begin
                        w_state_nxt = S_MUL;
                    end else if (w_special) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: w_state_nxt = S_DONE;
            S_DIV: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_valid = 1'b1;
                if (bus.i_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.i_flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op   <= OP_MUL;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_res  <= 32'd0;
            r_rem  <= 33'd0;
            r_cnt  <= 5'd0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (w_accept) begin
            r_op   <= w_op;
            r_cnt  <= 5'(DIV_ITER - 1);
            r_rem  <= 33'd0;
            r_qneg <= w_sdiv && (bus.i_x[31] ^ bus.i_y[31]);
            r_rneg <= w_sdiv && bus.i_x[31];
            // Dividend doubles as the quotient shift register during DIV.
            if (is_div(w_op)) begin
                r_a <= w_x_abs;
                r_b <= w_y_abs;
            end else begin
                r_a <= bus.i_x;
                r_b <= bus.i_y;
            end
            if (w_special) begin
                r_res <= w_special_res;
            end
        end else if (r_state == S_MUL) begin
            r_res <= w_mul_res;
        end else if (r_state == S_DIV) begin
            r_rem <= w_rem_nxt;
            r_a   <= w_quo;
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd0) begin
                r_res <= w_div_res;
            end
        end
    end

    assign bus.o_ready = w_ready;
    assign bus.o_valid = w_valid;
    assign bus.o_res   = r_res;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_seq
// Description : Directed self-checking bench for the RV32M sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mdu_seq_if bus ();

    mdu_seq dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, measure latency, optionally stall the consumer, then retire it.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int lat,
                         input int hold);
        int k;
        @(negedge clk);
        chk({tag, "/ready"}, {31'd0, bus.o_ready}, 32'd1);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_x     = x;
        bus.i_y     = y;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_x     = $urandom;
        bus.i_y     = $urandom;
        bus.i_op    = 3'($urandom);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.o_valid && k < 40);
        chk({tag, "/lat"}, 32'(k), 32'(lat));
        chk({tag, "/res"}, bus.o_res, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "/hold_res"}, bus.o_res, exp);
            chk({tag, "/hold_vld"}, {31'd0, bus.o_valid}, 32'd1);
            chk({tag, "/hold_rdy"}, {31'd0, bus.o_ready}, 32'd0);
        end
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        @(negedge clk);
        chk({tag, "/post_rdy"}, {31'd0, bus.o_ready}, 32'd1);
        chk({tag, "/post_vld"}, {31'd0, bus.o_valid}, 32'd0);
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_x     = x;
        bus.i_y     = y;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_op    = 3'd0;
        bus.i_x     = 32'd0;
        bus.i_y     = 32'd0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst/ready", {31'd0, bus.o_ready}, 32'd1);
        chk("rst/valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst/res",   bus.o_res, 32'd0);

        // Multiplies
        do_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 0);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 2, 0);
        do_op("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2, 0);

        // Normal divides, one with consumer backpressure
        do_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 5);
        do_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0);
        do_op("divu",   3'b101, 32'd100,        32'd7,         32'd14,        33, 0);
        do_op("remu",   3'b111, 32'd100,        32'd7,         32'd2,         33, 0);
        do_op("div_pn", 3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
        do_op("rem_pn", 3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33, 0);

        // Special cases
        do_op("divu_z", 3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0);
        do_op("rem_z",  3'b110, 32'd5,          32'd0,         32'd5,         1, 0);
        do_op("div_ov", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        do_op("rem_ov", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 0);

        // Flush in the middle of a divide
        start_op(3'b101, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        @(negedge clk);
        chk("flush/ready", {31'd0, bus.o_ready}, 32'd1);
        chk("flush/valid", {31'd0, bus.o_valid}, 32'd0);
        repeat (30) @(negedge clk);
        chk("flush/late_valid", {31'd0, bus.o_valid}, 32'd0);
        do_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 2, 0);

        // Reset in the middle of a divide
        start_op(3'b100, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(negedge clk);
        pulse_rst();
        @(negedge clk);
        chk("rst_div/valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_div/res",   bus.o_res, 32'd0);
        chk("rst_div/ready", {31'd0, bus.o_ready}, 32'd1);
        repeat (35) @(negedge clk);
        chk("rst_div/late_valid", {31'd0, bus.o_valid}, 32'd0);

        // Reset while holding a result in DONE
        start_op(3'b000, 32'd5, 32'd6);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.o_valid && k < 40);
        chk("rst_done/pre_res", bus.o_res, 32'd30);
        pulse_rst();
        @(negedge clk);
        chk("rst_done/valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_done/res",   bus.o_res, 32'd0);
        chk("rst_done/ready", {31'd0, bus.o_ready}, 32'd1);

        // Valid with flush in IDLE must not be accepted
        bus.i_valid = 1'b1;
        bus.i_flush = 1'b1;
        bus.i_op    = 3'b000;
        bus.i_x     = 32'd5;
        bus.i_y     = 32'd6;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_flush/valid", {31'd0, bus.o_valid}, 32'd0);
            chk("idle_flush/ready", {31'd0, bus.o_ready}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
